// File: rtl/pattern_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scan_scheduler
// Description : Round-robin time-shared "0110" serial pattern detector.
//               One granted channel per clock steps through a shared
//               detector. Per-channel 2-bit state and saturating match
//               counters are stored and written back after each step.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_scan_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH-1:0]       ch_bit,
  output logic [NUM_CH-1:0]       ch_ready,
  input  logic [NUM_CH-1:0]       ch_clear,
  output logic                    match_valid,
  output logic [CH_W-1:0]         match_ch,
  output logic [NUM_CH*CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_t;

  localparam logic [CH_W-1:0]  c_last_ch = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]  c_ch_one  = CH_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  // Per-channel state, flattened so the shared step can select by index.
  logic [NUM_CH*2-1:0] w_state_vec;

  logic [CH_W-1:0]   r_ptr;
  logic              r_match_valid;
  logic [CH_W-1:0]   r_match_ch;

  logic [NUM_CH-1:0] w_eligible;
  logic              w_grant_any;
  logic [CH_W-1:0]   w_grant_idx;
  logic [NUM_CH-1:0] w_ready;
  det_state_t        w_cur;
  det_state_t        w_next;
  logic              w_bit;
  logic              w_hit;
  logic [CH_W-1:0]   w_ptr_next;
  int                v_idx;

  // A clearing channel is never eligible, so clear always wins over transfer.
  assign w_eligible = ch_valid & ~ch_clear & {NUM_CH{run & ~rst}};

  // Round-robin search starting at the pointer, wrapping at NUM_CH-1.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_ready     = '0;
    v_idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      v_idx = (int'(r_ptr) + i) % NUM_CH;
      if (!w_grant_any && w_eligible[v_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = CH_W'(v_idx);
      end
    end
    if (w_grant_any) begin
      w_ready[w_grant_idx] = 1'b1;
    end
  end

  assign ch_ready = w_ready;

  assign w_cur = det_state_t'(w_state_vec[{w_grant_idx, 1'b0} +: 2]);
  assign w_bit = ch_bit[w_grant_idx];

  // Shared overlapping "0110" detector step on the granted channel's state.
  always_comb begin
    w_next = S0;
    w_hit  = 1'b0;
    case (w_cur)
      S0: w_next = w_bit ? S0 : S1;
      S1: w_next = w_bit ? S2 : S1;
      S2: w_next = w_bit ? S3 : S1;
      S3: begin
        w_next = w_bit ? S0 : S1;
        w_hit  = ~w_bit;
      end
      default: w_next = S0;
    endcase
  end

  assign w_ptr_next = (w_grant_idx == c_last_ch) ? '0 : (w_grant_idx + c_ch_one);

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      det_state_t       r_state;
      logic [CNT_W-1:0] r_cnt;

      // Channel state and counter: clear first, else write back on grant.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= S0;
          r_cnt   <= '0;
        end else if (ch_clear[k]) begin
          r_state <= S0;
          r_cnt   <= '0;
        end else if (w_grant_any && (w_grant_idx == CH_W'(k))) begin
          r_state <= w_next;
          if (w_hit && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
      end

      assign w_state_vec[2*k +: 2]         = r_state;
      assign match_cnt[k*CNT_W +: CNT_W]   = r_cnt;
    end
  endgenerate

  // Pointer advance and one-cycle registered match report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr         <= '0;
      r_match_valid <= 1'b0;
      r_match_ch    <= '0;
    end else begin
      r_match_valid <= w_grant_any & w_hit;
      if (w_grant_any) begin
        r_ptr <= w_ptr_next;
      end
      if (w_grant_any && w_hit) begin
        r_match_ch <= w_grant_idx;
      end
    end
  end

  assign match_valid = r_match_valid;
  assign match_ch    = r_match_ch;

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_scan_scheduler
// Description : Directed scoreboard bench for pattern_scan_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_scan_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    run = 1'b1;
  logic [NUM_CH-1:0]       ch_valid = '0;
  logic [NUM_CH-1:0]       ch_bit = '0;
  logic [NUM_CH-1:0]       ch_clear = '0;
  logic [NUM_CH-1:0]       ch_ready;
  logic                    match_valid;
  logic [CH_W-1:0]         match_ch;
  logic [NUM_CH*CNT_W-1:0] match_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  pattern_scan_scheduler #(
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .ch_valid   (ch_valid),
    .ch_bit     (ch_bit),
    .ch_ready   (ch_ready),
    .ch_clear   (ch_clear),
    .match_valid(match_valid),
    .match_ch   (match_ch),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int cnt_of(input int k);
    return int'(match_cnt[k*CNT_W +: CNT_W]);
  endfunction

  // One cycle of stimulus; ch_ready checked, expected match queued.
  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] b,
                       input logic [3:0] clr, input logic [3:0] exp_rdy,
                       input bit push, input int pch, input string nm);
    @(posedge clk);
    #1;
    run      = r;
    ch_valid = v;
    ch_bit   = b;
    ch_clear = clr;
    #1;
    check(nm, int'(ch_ready), int'(exp_rdy));
    if (push) exp_q.push_back(pch);
  endtask

  // Monitor: every match pulse must correspond to a queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (match_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_match actual=ch%0d required=none", match_ch);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("match_ch", int'(match_ch), e);
        end
      end
    end
  end

  initial begin
    int bits2[7];
    int seq[4];
    logic [3:0] b;
    bits2 = '{0, 1, 1, 0, 1, 1, 0};
    seq   = '{0, 1, 1, 0};

    // Reset state with requests present
    ch_valid = 4'hF;
    #3;
    check("rst_ready", int'(ch_ready), 0);
    check("rst_match_valid", int'(match_valid), 0);
    check("rst_cnt", int'(match_cnt), 0);
    #9;
    rst      = 1'b0;
    ch_valid = '0;

    // Single channel 0: 0110
    drive(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0, "t1_rdy");
    drive(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0, "t1_rdy");
    drive(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0, "t1_rdy");
    drive(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, "t1_rdy");
    drive(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, "idle_rdy");
    check("t1_cnt0", cnt_of(0), 1);

    // Overlap on channel 1: 0110110
    for (int i = 0; i < 7; i++) begin
      b = (bits2[i] != 0) ? 4'b0010 : 4'b0000;
      drive(1, 4'b0010, b, 4'b0000, 4'b0010, (i == 3) || (i == 6), 1, "t2_rdy");
    end
    // run=0: no grants; pulse from bit 7 still appears
    drive(0, 4'hF, 4'hF, 4'b0000, 4'b0000, 0, 0, "run0_rdy");
    drive(0, 4'hF, 4'hF, 4'b0000, 4'b0000, 0, 0, "run0_rdy");
    check("t2_cnt1", cnt_of(1), 2);
    check("run0_cnt0_held", cnt_of(0), 1);

    // Reset pulse between tests
    @(posedge clk);
    #1;
    rst      = 1'b1;
    run      = 1'b1;
    ch_valid = '0;
    #1;
    check("rst2_cnt", int'(match_cnt), 0);
    #3;
    rst = 1'b0;

    // Interleave: all valid, channel 2 fed 0110 across its grants
    for (int c = 0; c < 16; c++) begin
      b = 4'b1011 | (seq[(c + 1) / 4] != 0 ? 4'b0100 : 4'b0000);
      drive(1, 4'hF, b, 4'b0000, 4'(1 << (c % 4)), c == 14, 2, "t3_rdy");
    end
    drive(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, "idle_rdy");
    check("t3_cnt0", cnt_of(0), 0);
    check("t3_cnt1", cnt_of(1), 0);
    check("t3_cnt2", cnt_of(2), 1);
    check("t3_cnt3", cnt_of(3), 0);

    // Skip: move pointer to 1, then only channels 0 and 3 valid
    drive(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0, "t4_rdy");
    drive(1, 4'b1001, 4'b1001, 4'b0000, 4'b1000, 0, 0, "t4_skip_rdy");
    drive(1, 4'b1001, 4'b1001, 4'b0000, 4'b0001, 0, 0, "t4_skip_rdy");
    drive(1, 4'b1001, 4'b1001, 4'b0000, 4'b1000, 0, 0, "t4_skip_rdy");

    // Clear collision: channel 2 to S3, then clear with bit 0 pending
    drive(1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0, 0, "t5_rdy");
    drive(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 0, 0, "t5_rdy");
    drive(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 0, 0, "t5_rdy");
    drive(1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 0, 0, "t5_clr_rdy");
    drive(1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0, 0, "t5_accept_rdy");
    check("t5_cnt2_cleared", cnt_of(2), 0);
    drive(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 0, 0, "t5_rdy");
    drive(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 0, 0, "t5_rdy");
    drive(1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2, "t5_rdy");
    drive(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, "idle_rdy");
    check("t5_cnt2", cnt_of(2), 1);

    // Saturation: 260 matches on channel 0
    drive(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0, "t6_rdy");
    for (int m = 0; m < 260; m++) begin
      drive(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0, "t6_rdy");
      drive(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0, "t6_rdy");
      drive(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, "t6_rdy");
    end
    drive(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0, "t6_rdy");
    check("t6_cnt0_sat", cnt_of(0), 255);
    drive(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0, "t6_rdy");
    // This hit's pulse is dropped by the reset that follows
    drive(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0, "t6_rdy");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_match_valid", int'(match_valid), 0);
    check("midrst_cnt", int'(match_cnt), 0);
    check("midrst_ready", int'(ch_ready), 0);
    #2;
    rst      = 1'b0;
    ch_valid = 4'hF;
    ch_bit   = 4'h0;
    #1;
    check("midrst_ptr0", int'(ch_ready), 1);
    ch_valid = '0;

    repeat (3) @(posedge clk);
    #1;
    check("pending_matches", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
